// File: rtl/stack_pkg.sv
// Shared types for the data-stack sequencer.
//   stk_op_t       : opcode encoding presented on stack_ctrl.op
//   stk_pulse_t    : what one sequencer step does to the stack
//   stk_steps      : number of stack pulses an opcode expands into
//   stk_step_pulse : pulse issued at a given step of an opcode
package stack_pkg;

  localparam int STK_WIDTH = 36;
  localparam int STK_DEPTH = 64;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_DROP = 3'd2,
    OP_DUP  = 3'd3,
    OP_SWAP = 3'd4,
    OP_OVER = 3'd5,
    OP_NIP  = 3'd6,
    OP_REPL = 3'd7
  } stk_op_t;

  typedef enum logic [2:0] {
    NONE   = 3'd0,
    PUSH_T = 3'd1,  // push latched top
    PUSH_N = 3'd2,  // push latched next
    PUSH_D = 3'd3,  // push latched op_data
    DROP   = 3'd4
  } stk_pulse_t;

  function automatic logic [2:0] stk_steps(input stk_op_t op);
    logic [2:0] n;
    case (op)
      OP_PUSH, OP_DROP, OP_DUP, OP_OVER: n = 3'd1;
      OP_REPL: n = 3'd2;
      OP_NIP:  n = 3'd3;
      OP_SWAP: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic stk_pulse_t stk_step_pulse(input stk_op_t op, input logic [2:0] idx);
    stk_pulse_t p;
    p = NONE;
    case (op)
      OP_PUSH: if (idx == 3'd0) p = PUSH_D;
      OP_DROP: if (idx == 3'd0) p = DROP;
      OP_DUP:  if (idx == 3'd0) p = PUSH_T;
      OP_OVER: if (idx == 3'd0) p = PUSH_N;
      OP_SWAP: begin
        case (idx)
          3'd0, 3'd1: p = DROP;
          3'd2:       p = PUSH_T;
          3'd3:       p = PUSH_N;
          default:    p = NONE;
        endcase
      end
      OP_NIP: begin
        case (idx)
          3'd0, 3'd1: p = DROP;
          3'd2:       p = PUSH_T;
          default:    p = NONE;
        endcase
      end
      OP_REPL: begin
        case (idx)
          3'd0:    p = DROP;
          3'd1:    p = PUSH_D;
          default: p = NONE;
        endcase
      end
      default: p = NONE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/stack_ctrl.sv
// Sequencer between instruction decode and the 64x36 data stack. Accepts one
// opcode at a time, checks it for over/underflow against the tracked depth,
// and expands it into one registered push or drop pulse per cycle.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   op, op_data, op_valid    : request; op_ready high when idle
//   done, err                : completion / rejection pulses
//   ovf_sticky, unf_sticky   : latched error flags
//   depth                    : current entry count
//   stk_push, stk_drop, stk_D: pulses and write data to the stack
//   stk_top, stk_next        : stack read-back, sampled at accept
//   stk_rst                  : stack pointer reset (mirrors rst)
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int WIDTH = STK_WIDTH,
  parameter int DEPTH = STK_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_data,
  input  logic             op_valid,
  output logic             op_ready,
  output logic             done,
  output logic             err,
  output logic             ovf_sticky,
  output logic             unf_sticky,
  output logic [6:0]       depth,
  output logic             stk_push,
  output logic             stk_drop,
  output logic [WIDTH-1:0] stk_D,
  input  logic [WIDTH-1:0] stk_top,
  input  logic [WIDTH-1:0] stk_next,
  output logic             stk_rst
);

  // state | meaning
  // IDLE  | waiting for an op; rejected ops and NOP complete from here
  // STEPk | pulse k of the current op is on stk_push/stk_drop
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STEP1 = 3'd1,
    STEP2 = 3'd2,
    STEP3 = 3'd3,
    STEP4 = 3'd4
  } state_t;

  state_t           state_q;
  stk_op_t          op_q;
  logic [WIDTH-1:0] t0_q, n0_q, d0_q, stk_d_q;
  logic [6:0]       depth_q;
  logic             push_q, drop_q, done_q, err_q, ovf_q, unf_q;

  stk_op_t          op_in, op_sel;
  logic             idle, unf_hit, ovf_hit, more, last;
  logic [2:0]       step_num, n_steps;
  stk_pulse_t       nxt_pulse;
  logic [WIDTH-1:0] nxt_data;

  // In IDLE the first pulse is issued straight from the request and the live
  // stack read-back; later steps use the operands latched at accept.
  always_comb begin
    op_in     = stk_op_t'(op);
    idle      = (state_q == IDLE);
    op_sel    = idle ? op_in : op_q;
    step_num  = idle ? 3'd0 : state_q;
    n_steps   = stk_steps(op_sel);
    nxt_pulse = stk_step_pulse(op_sel, step_num);
    more      = (step_num < n_steps);
    last      = ((step_num + 3'd1) == n_steps);
    case (nxt_pulse)
      PUSH_T:  nxt_data = idle ? stk_top  : t0_q;
      PUSH_N:  nxt_data = idle ? stk_next : n0_q;
      PUSH_D:  nxt_data = idle ? op_data  : d0_q;
      default: nxt_data = stk_d_q;
    endcase
    unf_hit = 1'b0;
    ovf_hit = 1'b0;
    case (op_in)
      OP_DROP, OP_REPL:         unf_hit = (depth_q == 7'd0);
      OP_SWAP, OP_NIP:          unf_hit = (depth_q < 7'd2);
      OP_OVER: begin
        unf_hit = (depth_q < 7'd2);
        ovf_hit = (depth_q >= 7'(DEPTH));
      end
      OP_DUP: begin
        unf_hit = (depth_q == 7'd0);
        ovf_hit = (depth_q >= 7'(DEPTH));
      end
      OP_PUSH:                  ovf_hit = (depth_q >= 7'(DEPTH));
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      t0_q    <= '0;
      n0_q    <= '0;
      d0_q    <= '0;
      stk_d_q <= '0;
      depth_q <= '0;
      push_q  <= 1'b0;
      drop_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      push_q <= 1'b0;
      drop_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (push_q)      depth_q <= depth_q + 7'd1;
      else if (drop_q) depth_q <= depth_q - 7'd1;

      if (idle) begin
        if (op_valid) begin
          op_q <= op_in;
          t0_q <= stk_top;
          n0_q <= stk_next;
          d0_q <= op_data;
          if (op_in == OP_NOP) begin
            done_q <= 1'b1;
          end else if (unf_hit || ovf_hit) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
            if (unf_hit) unf_q <= 1'b1;
            if (ovf_hit) ovf_q <= 1'b1;
          end else begin
            push_q  <= (nxt_pulse != NONE) && (nxt_pulse != DROP);
            drop_q  <= (nxt_pulse == DROP);
            stk_d_q <= nxt_data;
            done_q  <= last;
            state_q <= STEP1;
          end
        end
      end else if (more) begin
        push_q  <= (nxt_pulse != NONE) && (nxt_pulse != DROP);
        drop_q  <= (nxt_pulse == DROP);
        stk_d_q <= nxt_data;
        done_q  <= last;
        state_q <= state_t'(state_q + 3'd1);
      end else begin
        state_q <= IDLE;
      end
    end
  end

  assign op_ready   = idle & ~rst;
  assign done       = done_q;
  assign err        = err_q;
  assign ovf_sticky = ovf_q;
  assign unf_sticky = unf_q;
  assign depth      = depth_q;
  assign stk_push   = push_q;
  assign stk_drop   = drop_q;
  assign stk_D      = stk_d_q;
  assign stk_rst    = rst;

endmodule

// File: tb/tb_stack_ctrl.sv
module tb_stack_ctrl;

  localparam logic [2:0] NOP = 3'd0, PSH = 3'd1, DRP = 3'd2, DUP = 3'd3,
                         SWP = 3'd4, OVR = 3'd5, NIP = 3'd6, RPL = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  op = 3'd0;
  logic [35:0] op_data = '0;
  logic        op_valid = 1'b0;
  logic        op_ready, done, err, ovf_sticky, unf_sticky;
  logic [6:0]  depth;
  logic        stk_push, stk_drop, stk_rst;
  logic [35:0] stk_D, stk_top, stk_next;

  int checks = 0;
  int errors = 0;

  // trace of the six cycles following an accept edge
  logic        tr_push [6];
  logic        tr_drop [6];
  logic        tr_done [6];
  logic        tr_err  [6];
  logic        tr_ready[6];
  logic [35:0] tr_D    [6];

  // behavioural stack the controller drives
  logic [35:0] mem [64];
  int          sp = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (stk_rst) sp <= 0;
    else if (stk_push && sp < 64) begin mem[sp] <= stk_D; sp <= sp + 1; end
    else if (stk_drop && sp > 0) sp <= sp - 1;
  end

  always_comb begin
    stk_top  = '0;
    stk_next = '0;
    if (sp >= 1) stk_top  = mem[sp-1];
    if (sp >= 2) stk_next = mem[sp-2];
  end

  stack_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .op_data(op_data), .op_valid(op_valid),
    .op_ready(op_ready), .done(done), .err(err), .ovf_sticky(ovf_sticky),
    .unf_sticky(unf_sticky), .depth(depth), .stk_push(stk_push), .stk_drop(stk_drop),
    .stk_D(stk_D), .stk_top(stk_top), .stk_next(stk_next), .stk_rst(stk_rst)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Issue one op and record the following six cycles (sampled 1 after each edge).
  task automatic run_op(input logic [2:0] o, input logic [35:0] d);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!op_ready && guard < 20) begin @(negedge clk); guard++; end
    checks++;
    if (op_ready !== 1'b1) begin
      $display("FAIL run_op_ready got %b want 1", op_ready);
      errors++;
    end
    op = o; op_data = d; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0; op = NOP;
    for (int i = 0; i < 6; i++) begin
      tr_push[i] = stk_push; tr_drop[i] = stk_drop; tr_done[i] = done;
      tr_err[i] = err; tr_ready[i] = op_ready; tr_D[i] = stk_D;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (op_ready !== 1'b0 || stk_rst !== 1'b1) begin
      $display("FAIL reset_ready got ready=%b stk_rst=%b want 0/1", op_ready, stk_rst); errors++;
    end
    @(posedge clk); #1;
    checks++;
    if (depth !== 7'd0 || stk_push !== 1'b0 || stk_drop !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      $display("FAIL reset_outputs got depth=%0d push=%b drop=%b done=%b err=%b want 0", depth, stk_push, stk_drop, done, err);
      errors++;
    end
    checks++;
    if (ovf_sticky !== 1'b0 || unf_sticky !== 1'b0 || stk_D !== 36'd0) begin
      $display("FAIL reset_flags got ovf=%b unf=%b D=%0d want 0", ovf_sticky, unf_sticky, stk_D); errors++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (op_ready !== 1'b1 || stk_rst !== 1'b0) begin
      $display("FAIL reset_release got ready=%b stk_rst=%b want 1/0", op_ready, stk_rst); errors++;
    end
  endtask

  task automatic test_push();
    logic [35:0] vals [3];
    vals[0] = 36'd16; vals[1] = 36'd137; vals[2] = 36'd3;
    for (int k = 0; k < 3; k++) begin
      run_op(PSH, vals[k]);
      checks++;
      if (tr_push[0] !== 1'b1 || tr_drop[0] !== 1'b0 || tr_D[0] !== vals[k]) begin
        $display("FAIL push_pulse%0d got push=%b drop=%b D=%0d want 1/0/%0d", k, tr_push[0], tr_drop[0], tr_D[0], vals[k]);
        errors++;
      end
      checks++;
      if (tr_done[0] !== 1'b1 || tr_err[0] !== 1'b0 || tr_push[1] !== 1'b0 || tr_done[1] !== 1'b0) begin
        $display("FAIL push_done%0d got done0=%b err0=%b push1=%b done1=%b want 1/0/0/0", k, tr_done[0], tr_err[0], tr_push[1], tr_done[1]);
        errors++;
      end
      checks++;
      if (tr_ready[0] !== 1'b0 || tr_ready[1] !== 1'b1) begin
        $display("FAIL push_occupancy%0d got ready0=%b ready1=%b want 0/1", k, tr_ready[0], tr_ready[1]);
        errors++;
      end
    end
    checks++;
    if (depth !== 7'd3) begin $display("FAIL push_depth got %0d want 3", depth); errors++; end
  endtask

  task automatic test_swap();
    logic ep, ed;
    run_op(SWP, 36'd0);
    for (int i = 0; i < 6; i++) begin
      ed = (i < 2);
      ep = (i == 2 || i == 3);
      checks++;
      if (tr_push[i] !== ep || tr_drop[i] !== ed || tr_done[i] !== (i == 3) || tr_ready[i] !== (i >= 4)) begin
        $display("FAIL swap_cycle%0d got push=%b drop=%b done=%b ready=%b want %b/%b/%b/%b",
                 i, tr_push[i], tr_drop[i], tr_done[i], tr_ready[i], ep, ed, (i == 3), (i >= 4));
        errors++;
      end
    end
    checks++;
    if (tr_D[2] !== 36'd3 || tr_D[3] !== 36'd137) begin
      $display("FAIL swap_data got %0d,%0d want 3,137", tr_D[2], tr_D[3]); errors++;
    end
    checks++;
    if (stk_top !== 36'd137 || stk_next !== 36'd3 || depth !== 7'd3) begin
      $display("FAIL swap_result got top=%0d next=%0d depth=%0d want 137/3/3", stk_top, stk_next, depth); errors++;
    end
  endtask

  task automatic test_nop();
    run_op(NOP, 36'd99);
    checks++;
    if (tr_done[0] !== 1'b1 || tr_err[0] !== 1'b0 || tr_push[0] !== 1'b0 || tr_drop[0] !== 1'b0 || tr_ready[0] !== 1'b1) begin
      $display("FAIL nop got done=%b err=%b push=%b drop=%b ready=%b want 1/0/0/0/1",
               tr_done[0], tr_err[0], tr_push[0], tr_drop[0], tr_ready[0]);
      errors++;
    end
    checks++;
    if (depth !== 7'd3) begin $display("FAIL nop_depth got %0d want 3", depth); errors++; end
  endtask

  task automatic test_underflow();
    do_reset();
    run_op(DRP, 36'd0);
    checks++;
    if (tr_push[0] !== 1'b0 || tr_drop[0] !== 1'b0 || tr_done[0] !== 1'b1 || tr_err[0] !== 1'b1 || tr_ready[0] !== 1'b1) begin
      $display("FAIL unf_reject got push=%b drop=%b done=%b err=%b ready=%b want 0/0/1/1/1",
               tr_push[0], tr_drop[0], tr_done[0], tr_err[0], tr_ready[0]);
      errors++;
    end
    checks++;
    if (unf_sticky !== 1'b1 || ovf_sticky !== 1'b0 || depth !== 7'd0) begin
      $display("FAIL unf_flags got unf=%b ovf=%b depth=%0d want 1/0/0", unf_sticky, ovf_sticky, depth); errors++;
    end
    run_op(PSH, 36'd5);
    checks++;
    if (tr_push[0] !== 1'b1 || tr_D[0] !== 36'd5 || tr_err[0] !== 1'b0 || depth !== 7'd1) begin
      $display("FAIL unf_then_push got push=%b D=%0d err=%b depth=%0d want 1/5/0/1", tr_push[0], tr_D[0], tr_err[0], depth);
      errors++;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 64; k++) run_op(PSH, 36'(k + 100));
    checks++;
    if (depth !== 7'd64 || stk_top !== 36'd163) begin
      $display("FAIL ovf_fill got depth=%0d top=%0d want 64/163", depth, stk_top); errors++;
    end
    run_op(DUP, 36'd0);
    checks++;
    if (tr_push[0] !== 1'b0 || tr_err[0] !== 1'b1 || tr_done[0] !== 1'b1 || ovf_sticky !== 1'b1 || unf_sticky !== 1'b0 || depth !== 7'd64) begin
      $display("FAIL ovf_dup got push=%b err=%b done=%b ovf=%b unf=%b depth=%0d want 0/1/1/1/0/64",
               tr_push[0], tr_err[0], tr_done[0], ovf_sticky, unf_sticky, depth);
      errors++;
    end
    run_op(PSH, 36'd7);
    checks++;
    if (tr_push[0] !== 1'b0 || tr_err[0] !== 1'b1 || depth !== 7'd64) begin
      $display("FAIL ovf_push got push=%b err=%b depth=%0d want 0/1/64", tr_push[0], tr_err[0], depth); errors++;
    end
    run_op(DRP, 36'd0);
    checks++;
    if (tr_drop[0] !== 1'b1 || tr_err[0] !== 1'b0 || tr_done[0] !== 1'b1 || depth !== 7'd63) begin
      $display("FAIL ovf_drop got drop=%b err=%b done=%b depth=%0d want 1/0/1/63", tr_drop[0], tr_err[0], tr_done[0], depth);
      errors++;
    end
  endtask

  task automatic test_repl();
    do_reset();
    run_op(PSH, 36'd7);
    run_op(PSH, 36'd9);
    run_op(RPL, 36'd42);
    checks++;
    if (tr_drop[0] !== 1'b1 || tr_push[0] !== 1'b0 || tr_push[1] !== 1'b1 || tr_drop[1] !== 1'b0 || tr_D[1] !== 36'd42) begin
      $display("FAIL repl_pulses got d0=%b p0=%b p1=%b d1=%b D1=%0d want 1/0/1/0/42",
               tr_drop[0], tr_push[0], tr_push[1], tr_drop[1], tr_D[1]);
      errors++;
    end
    checks++;
    if (tr_done[0] !== 1'b0 || tr_done[1] !== 1'b1 || tr_ready[1] !== 1'b0 || tr_ready[2] !== 1'b1) begin
      $display("FAIL repl_timing got done0=%b done1=%b ready1=%b ready2=%b want 0/1/0/1",
               tr_done[0], tr_done[1], tr_ready[1], tr_ready[2]);
      errors++;
    end
    checks++;
    if (stk_top !== 36'd42 || stk_next !== 36'd7 || depth !== 7'd2) begin
      $display("FAIL repl_result got top=%0d next=%0d depth=%0d want 42/7/2", stk_top, stk_next, depth); errors++;
    end
    run_op(OVR, 36'd0);
    checks++;
    if (tr_push[0] !== 1'b1 || tr_D[0] !== 36'd7 || depth !== 7'd3) begin
      $display("FAIL over got push=%b D=%0d depth=%0d want 1/7/3", tr_push[0], tr_D[0], depth); errors++;
    end
    run_op(NIP, 36'd0);
    checks++;
    if (tr_D[2] !== 36'd7 || tr_done[2] !== 1'b1 || tr_ready[3] !== 1'b1 || depth !== 7'd2 || stk_top !== 36'd7 || stk_next !== 36'd7) begin
      $display("FAIL nip got D2=%0d done2=%b ready3=%b depth=%0d top=%0d next=%0d want 7/1/1/2/7/7",
               tr_D[2], tr_done[2], tr_ready[3], depth, stk_top, stk_next);
      errors++;
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    run_op(DRP, 36'd0);
    run_op(PSH, 36'd1);
    run_op(PSH, 36'd2);
    run_op(PSH, 36'd3);
    @(negedge clk);
    op = SWP; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0; op = NOP;
    @(posedge clk); #1;
    checks++;
    if (stk_drop !== 1'b1 || unf_sticky !== 1'b1) begin
      $display("FAIL midrst_step2 got drop=%b unf=%b want 1/1", stk_drop, unf_sticky); errors++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (stk_push !== 1'b0 || stk_drop !== 1'b0 || done !== 1'b0 || err !== 1'b0 || depth !== 7'd0 ||
        unf_sticky !== 1'b0 || ovf_sticky !== 1'b0 || op_ready !== 1'b0) begin
      $display("FAIL midrst_clear got push=%b drop=%b done=%b err=%b depth=%0d unf=%b ovf=%b ready=%b want all 0",
               stk_push, stk_drop, done, err, depth, unf_sticky, ovf_sticky, op_ready);
      errors++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (op_ready !== 1'b1) begin $display("FAIL midrst_ready got %b want 1", op_ready); errors++; end
    @(posedge clk); #1;
    checks++;
    if (stk_push !== 1'b0 || stk_drop !== 1'b0 || done !== 1'b0 || depth !== 7'd0) begin
      $display("FAIL midrst_abandon got push=%b drop=%b done=%b depth=%0d want 0/0/0/0", stk_push, stk_drop, done, depth);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_push();
    test_swap();
    test_nop();
    test_underflow();
    test_overflow();
    test_repl();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
